// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - decoded control word pipeline D->E->M->W with load-use
// stall, redirect bubbles and retired-instruction counting.
module ctrl_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        RedirectE,
  input  logic        ValidD,
  input  logic        RegWriteD,
  input  logic        MemWriteD,
  input  logic        ALUSrcD,
  input  logic        PCResultSrcD,
  input  logic [2:0]  ResultSrcD,
  input  logic [1:0]  ALUOpD,
  input  logic [4:0]  rdD,
  input  logic [4:0]  rs1D,
  input  logic [4:0]  rs2D,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        ALUSrcE,
  output logic        PCResultSrcE,
  output logic [2:0]  ResultSrcE,
  output logic [1:0]  ALUOpE,
  output logic [4:0]  rdE,
  output logic        ValidE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [2:0]  ResultSrcM,
  output logic [4:0]  rdM,
  output logic        ValidM,
  output logic        RegWriteW,
  output logic [2:0]  ResultSrcW,
  output logic [4:0]  rdW,
  output logic        ValidW,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic [31:0] InstRet
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       pc_result_src;
    logic [2:0] result_src;
    logic [1:0] alu_op;
    logic [4:0] rd;
    logic       valid;
  } ex_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic [2:0] result_src;
    logic [4:0] rd;
    logic       valid;
  } mem_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [2:0] result_src;
    logic [4:0] rd;
    logic       valid;
  } wb_ctrl_t;

  localparam logic [2:0] RESULT_LOAD = 3'b001;

  ex_ctrl_t  ex_q,  ex_d;
  mem_ctrl_t mem_q, mem_d;
  wb_ctrl_t  wb_q,  wb_d;
  logic [31:0] instret_q, instret_d;
  logic        lw_stall;

  // rd = 0 is never a real destination, so it can never create a hazard
  assign lw_stall = ex_q.valid & (ex_q.result_src == RESULT_LOAD) & (ex_q.rd != 5'd0) &
                    ((ex_q.rd == rs1D) | (ex_q.rd == rs2D));

  assign StallF = lw_stall & ~RedirectE & ~hold;
  assign StallD = lw_stall & ~RedirectE & ~hold;
  assign FlushD = RedirectE & ~hold;

  always_comb begin
    ex_d = '0;
    if (!(lw_stall || RedirectE)) begin
      ex_d.reg_write     = RegWriteD;
      ex_d.mem_write     = MemWriteD;
      ex_d.alu_src       = ALUSrcD;
      ex_d.pc_result_src = PCResultSrcD;
      ex_d.result_src    = ResultSrcD;
      ex_d.alu_op        = ALUOpD;
      ex_d.rd            = rdD;
      ex_d.valid         = ValidD;
    end

    mem_d.reg_write  = ex_q.reg_write;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.result_src = ex_q.result_src;
    mem_d.rd         = ex_q.rd;
    mem_d.valid      = ex_q.valid;

    wb_d.reg_write  = mem_q.reg_write;
    wb_d.result_src = mem_q.result_src;
    wb_d.rd         = mem_q.rd;
    wb_d.valid      = mem_q.valid;

    instret_d = instret_q + {31'd0, wb_q.valid};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      instret_q <= '0;
    end else if (!hold) begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      instret_q <= instret_d;
    end
  end

  assign RegWriteE    = ex_q.reg_write;
  assign MemWriteE    = ex_q.mem_write;
  assign ALUSrcE      = ex_q.alu_src;
  assign PCResultSrcE = ex_q.pc_result_src;
  assign ResultSrcE   = ex_q.result_src;
  assign ALUOpE       = ex_q.alu_op;
  assign rdE          = ex_q.rd;
  assign ValidE       = ex_q.valid;

  assign RegWriteM  = mem_q.reg_write;
  assign MemWriteM  = mem_q.mem_write;
  assign ResultSrcM = mem_q.result_src;
  assign rdM        = mem_q.rd;
  assign ValidM     = mem_q.valid;

  assign RegWriteW  = wb_q.reg_write;
  assign ResultSrcW = wb_q.result_src;
  assign rdW        = wb_q.rd;
  assign ValidW     = wb_q.valid;

  assign InstRet = instret_q;

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries the decoded control word of each instruction from the decode stage down through the EX, MEM and WB pipeline registers of the pipelined RISC-V core. It sits directly downstream of the main decoder and consumes its per-instruction control outputs. It also detects load-use hazards, inserts bubbles on stalls and taken redirects, and counts retired instructions.

## Interface
- no parameters; all widths fixed by the control-word definition
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears every register immediately
- hold  in  1  global freeze (memory wait); when 1 no pipeline register changes
- RedirectE  in  1  instruction in EX redirects PC (taken branch / jal / jalr)
- ValidD  in  1  decode slot holds a real instruction
- RegWriteD, MemWriteD, ALUSrcD, PCResultSrcD  in  1 each  decoder outputs
- ResultSrcD  in  3  result select (3'b001 = load)
- ALUOpD  in  2  ALU op class
- rdD, rs1D, rs2D  in  5 each  register indices of decode instruction
- RegWriteE, MemWriteE, ALUSrcE, PCResultSrcE  out  1 each; ResultSrcE out 3; ALUOpE out 2; rdE out 5; ValidE out 1
- RegWriteM, MemWriteM  out  1 each; ResultSrcM out 3; rdM out 5; ValidM out 1
- RegWriteW  out  1; ResultSrcW out 3; rdW out 5; ValidW out 1
- StallF, StallD  out  1 each  hold PC and IF/ID register
- FlushD  out  1  clear IF/ID register
- InstRet  out  32  retired-instruction count

## Operation
- Bubble = all control fields 0, rd 0, valid 0.
- lwStall (combinational) = ValidE & (ResultSrcE == 3'b001) & (rdE != 0) & ((rdE == rs1D) | (rdE == rs2D)).
- StallF = StallD = lwStall & ~RedirectE & ~hold; FlushD = RedirectE & ~hold.
- Per rising edge when hold = 0:
  - E <= bubble if (lwStall | RedirectE), else D-stage inputs (valid = ValidD).
  - M <= E fields (RegWrite, MemWrite, ResultSrc, rd, valid).
  - W <= M fields.
  - InstRet <= InstRet + 1 if ValidW, wraps 2^32-1 -> 0.
- When hold = 1: all E/M/W registers and InstRet keep their value; StallF/StallD/FlushD forced 0 (hold is applied to fetch/decode externally).
- RedirectE and lwStall simultaneous: redirect wins; D instruction is wrong-path, so no stall, FlushD = 1, E gets bubble.
- rd = 0 never causes a stall.
- Bubbles never increment InstRet.

## Timing
- Reset: all outputs 0 (all E/M/W fields, valids, InstRet); StallF/StallD/FlushD 0 since ValidE = 0.
- Reset asserted mid-operation: state clears asynchronously, in-flight instructions are discarded, nothing counts.
- Latency D->E->M->W: 1 cycle per stage; an instruction valid in D at edge n appears in W after edge n+2 (no stall/hold).
- InstRet counts the W instruction one edge after it reaches W.
- Load-use: exactly one bubble; stall outputs high for exactly one cycle per hazard.
- Hold then release: pipeline resumes with identical contents; a RedirectE pending during hold takes effect on the first non-hold edge.

## Test plan
- Reset pulse mid-stream with ValidE = ValidM = ValidW = 1 -> all outputs 0 asynchronously, before next clk edge; InstRet = 0.
- Three back-to-back valid R-type ops (RegWriteD = 1, rdD = 5, 6, 7) -> rdW = 5, 6, 7 on consecutive cycles; InstRet = 3 one cycle after the last.
- Load rd = 5 in E, D has rs1D = 5 -> StallF = StallD = 1 for one cycle; next E is bubble; then dependent op enters E; load with rdE = 0 -> no stall.
- RedirectE = 1 coincident with load-use hazard -> StallD = 0, FlushD = 1, E bubble; InstRet skips the squashed slot.
- hold = 1 for 4 cycles with full pipe -> E/M/W and InstRet unchanged, stall/flush outputs 0; on release, flow resumes with no instruction lost or duplicated.
- InstRet preset via 2^32-1 retirements (forced) + one more ValidW -> InstRet = 0.
